tpu_sequencer: RTL and testbench

Controller that sequences one complete weight-stationary pass through the DEPTH×DEPTH `TPU` systolic array and captures the final accumulator row. It sits directly in front of `TPU` and drives its `control`, `wt_arr` and `data_arr` inputs. It loads DEPTH weight columns with `control=1`, then streams input rows with the diagonal lane skew applied internally, flushes the array, and latches `acc_out`. Upstream logic only writes weight columns and offers unskewed rows.

---
 rtl/tpu_seq_pkg.sv | 22 ++
 rtl/tpu_sequencer_skew_line.sv | 28 ++
 rtl/tpu_sequencer.sv | 139 +++++++++++++
 tb/tb_tpu_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types and default geometry for the TPU pass sequencer.
package tpu_seq_pkg;

  localparam int unsigned LANE_W    = 16;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned DRAIN_DEF = 8;
  localparam int unsigned ROW_W     = LANE_W * DEPTH_DEF;
  localparam int unsigned ACC_ROW_W = ACC_W * DEPTH_DEF;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SETTLE,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/tpu_sequencer_skew_line.sv
// Per-lane delay line with synchronous clear, used to build the diagonal skew.
module skew_line #(
  parameter int unsigned W   = 16,
  parameter int unsigned DLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DLY; k++) r_sr[k] <= '0;
    end else if (i_clr) begin
      for (int unsigned k = 0; k < DLY; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned k = 1; k < DLY; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DLY-1];

endmodule

// File: rtl/tpu_sequencer.sv
// Sequences one weight-stationary pass through the systolic array:
// weight load, skewed row feed, flush, drain and accumulator capture.
module tpu_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned BIT_WIDTH    = LANE_W,
  parameter int unsigned ACC_WIDTH    = ACC_W,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wt_we,
  input  logic [$clog2(DEPTH)-1:0]     wt_addr,
  input  logic [BIT_WIDTH*DEPTH-1:0]   wt_wdata,
  input  logic                         start,
  input  logic [15:0]                  n_rows,
  input  logic                         row_valid,
  input  logic [BIT_WIDTH*DEPTH-1:0]   row_data,
  output logic                         row_ready,
  output logic                         control,
  output logic [BIT_WIDTH*DEPTH-1:0]   wt_arr,
  output logic [BIT_WIDTH*DEPTH-1:0]   data_arr,
  input  logic [ACC_WIDTH*DEPTH-1:0]   acc_out,
  output logic                         busy,
  output logic                         res_valid,
  output logic [ACC_WIDTH*DEPTH-1:0]   res_data
);

  localparam int unsigned DW  = BIT_WIDTH * DEPTH;
  localparam int unsigned RWD = ACC_WIDTH * DEPTH;
  localparam int unsigned AW  = $clog2(DEPTH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [15:0]      r_nrows, r_rows;
  logic [DW-1:0]    r_wbuf [DEPTH];
  logic             r_control, r_row_ready, r_busy, r_res_valid;
  logic [DW-1:0]    r_wt_arr;
  logic [RWD-1:0]   r_res_data;
  logic [DW-1:0]    w_skew_in, w_skew_out;
  logic             w_start_acc, w_hs, w_last_row, w_capture;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_hs        = r_row_ready && row_valid;
  assign w_last_row  = w_hs && ((r_rows + 16'd1) == r_nrows);
  assign w_skew_in   = w_hs ? row_data : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE:   if (start) w_state_nxt = LOAD_W;
      LOAD_W: begin
        if (r_cnt == CNT_W'(DEPTH - 1)) w_state_nxt = SETTLE;
        else                            w_cnt_nxt   = r_cnt + 1'b1;
      end
      SETTLE: w_state_nxt = (r_nrows == 16'd0) ? FLUSH : FEED;
      FEED:   if (w_last_row) w_state_nxt = FLUSH;
      FLUSH: begin
        if (r_cnt == CNT_W'(DEPTH - 2)) w_state_nxt = DRAIN;
        else                            w_cnt_nxt   = r_cnt + 1'b1;
      end
      DRAIN: begin
        if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nrows     <= '0;
      r_rows      <= '0;
      r_control   <= 1'b0;
      r_wt_arr    <= '0;
      r_row_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start_acc) begin
        r_nrows <= n_rows;
        r_rows  <= '0;
      end else if (w_hs) begin
        r_rows <= r_rows + 16'd1;
      end
      r_control   <= (w_state_nxt == LOAD_W);
      r_wt_arr    <= (w_state_nxt == LOAD_W) ? r_wbuf[w_cnt_nxt[AW-1:0]] : '0;
      r_row_ready <= (w_state_nxt == FEED);
      r_busy      <= (w_state_nxt != IDLE);
      r_res_valid <= (w_state_nxt == DONE);
      if (w_capture) r_res_data <= acc_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_wbuf[k] <= '0;
    end else if ((r_state == IDLE) && wt_we) begin
      r_wbuf[wt_addr] <= wt_wdata;
    end
  end

  // Lane g gets g skew stages plus one stage acting as the data_arr output register.
  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    skew_line #(
      .W   (BIT_WIDTH),
      .DLY (g + 1)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_start_acc),
      .i_d   (w_skew_in[g*BIT_WIDTH +: BIT_WIDTH]),
      .o_q   (w_skew_out[g*BIT_WIDTH +: BIT_WIDTH])
    );
  end

  assign control   = r_control;
  assign wt_arr    = r_wt_arr;
  assign data_arr  = w_skew_out;
  assign row_ready = r_row_ready;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer; a simple lane-sum accumulator stands in for the array.
module tb_tpu_sequencer;
  import tpu_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int DRAIN = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wt_we;
  logic [1:0]           wt_addr;
  logic [ROW_W-1:0]     wt_wdata;
  logic                 start;
  logic [15:0]          n_rows;
  logic                 row_valid;
  logic [ROW_W-1:0]     row_data;
  logic                 row_ready;
  logic                 control;
  logic [ROW_W-1:0]     wt_arr;
  logic [ROW_W-1:0]     data_arr;
  logic [ACC_ROW_W-1:0] acc_out;
  logic                 busy;
  logic                 res_valid;
  logic [ACC_ROW_W-1:0] res_data;

  logic                 acc_clr;
  logic [ACC_ROW_W-1:0] last_res;
  int                   n_total = 0;
  int                   n_bad   = 0;

  localparam logic [ACC_ROW_W-1:0] RES4 = {40'd36, 40'd32, 40'd28, 40'd24};

  tpu_sequencer #(
    .BIT_WIDTH    (16),
    .ACC_WIDTH    (40),
    .DEPTH        (DEPTH),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_wdata  (wt_wdata),
    .start     (start),
    .n_rows    (n_rows),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_ready (row_ready),
    .control   (control),
    .wt_arr    (wt_arr),
    .data_arr  (data_arr),
    .acc_out   (acc_out),
    .busy      (busy),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the array: each accumulator lane sums the data lane it sees.
  always @(posedge clk) begin
    if (acc_clr) acc_out <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        acc_out[40*i +: 40] <= acc_out[40*i +: 40] + 40'(data_arr[16*i +: 16]);
  end

  task automatic check(input string tag, input logic [ACC_ROW_W-1:0] got,
                       input logic [ACC_ROW_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int j);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[16*i +: 16] = 16'(4*j + i);
    return r;
  endfunction

  // Row j enters in FEED cycle 6+j, lane 0 shows it one cycle later, lane i i cycles after that.
  function automatic logic [ROW_W-1:0] exp_data(input int cyc);
    logic [ROW_W-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      j = cyc - 7 - i;
      if (j >= 0 && j < 4) r[16*i +: 16] = 16'(4*j + i);
    end
    return r;
  endfunction

  task automatic write_w(input int k, input logic [ROW_W-1:0] d);
    wt_we = 1'b1; wt_addr = 2'(k); wt_wdata = d;
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic run_pass(input int n, input int bub_at, input bit do_skew, input bit poke,
                          input bit wt_on, input logic [ACC_ROW_W-1:0] exp_res);
    int nbub, lat, sent;
    bit prev_rdy, prev_vld;
    logic [ROW_W-1:0] exp_wt, one;
    logic [ACC_ROW_W-1:0] acc_prev;
    nbub = (bub_at > 0) ? 2 : 0;
    lat  = 1 + DEPTH + 1 + n + nbub + (DEPTH - 1) + DRAIN;
    one  = 64'h2;
    acc_prev = '0;
    n_rows = 16'(n); start = 1'b1; acc_clr = 1'b1; row_valid = 1'b0; sent = 0;
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      prev_rdy = row_ready; prev_vld = row_valid;
      @(posedge clk); #1;
      start = 1'b0; acc_clr = 1'b0; wt_we = 1'b0;
      if (prev_rdy && prev_vld) sent++;
      row_valid = (sent < n) && !(bub_at > 0 && cyc >= bub_at && cyc < bub_at + 2);
      row_data  = mk_row(sent);
      if (cyc == 1) check("res_hold", res_data, last_res);
      if (cyc <= 5) begin
        exp_wt = (cyc <= 4 && wt_on) ? (one << (16*(4-cyc))) : '0;
        check("control", control, cyc <= 4);
        check("wt_arr", wt_arr, exp_wt);
      end
      check("row_ready", row_ready, cyc >= 6 && cyc < 6 + n + nbub);
      check("res_valid", res_valid, cyc == lat);
      check("busy", busy, cyc <= lat);
      check("data_x", $isunknown(data_arr), 1'b0);
      if (do_skew) check("data_arr", data_arr, exp_data(cyc));
      if (cyc == lat - 1) acc_prev = acc_out;
      if (cyc == lat) begin
        check("res_data", res_data, exp_res);
        check("res_vs_acc", res_data, acc_prev);
      end
      if (poke && cyc == 3) begin wt_we = 1'b1; wt_addr = 2'd3; wt_wdata = '1; end
      if (poke && cyc == 10) begin start = 1'b1; n_rows = 16'd7; end
    end
    last_res = exp_res;
  endtask

  initial begin
    rst_n = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_wdata = '0; start = 1'b0;
    n_rows = '0; row_valid = 1'b0; row_data = '0; acc_clr = 1'b1; last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", control, 1'b0);
    check("rst_wt_arr", wt_arr, '0);
    check("rst_data_arr", data_arr, '0);
    check("rst_row_ready", row_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;

    for (int k = 0; k < DEPTH; k++) write_w(k, 64'h2 << (16*(3-k)));

    run_pass(4, 0, 1'b1, 1'b1, 1'b1, RES4);   // skew, busy-write and busy-start pokes
    run_pass(4, 7, 1'b0, 1'b0, 1'b1, RES4);   // two bubbles, back-to-back
    run_pass(0, 0, 1'b0, 1'b0, 1'b1, '0);     // empty pass

    n_rows = 16'd4; start = 1'b1; acc_clr = 1'b1; row_valid = 1'b1; row_data = mk_row(0);
    repeat (7) begin
      @(posedge clk); #1;
      start = 1'b0; acc_clr = 1'b0;
    end
    check("mid_busy", busy, 1'b1);
    check("mid_row_ready", row_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_control", control, 1'b0);
    check("mrst_wt_arr", wt_arr, '0);
    check("mrst_data_arr", data_arr, '0);
    check("mrst_row_ready", row_ready, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_res_valid", res_valid, 1'b0);
    check("mrst_res_data", res_data, '0);
    row_valid = 1'b0;
    last_res  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 1'b0);
    run_pass(4, 0, 1'b1, 1'b0, 1'b0, RES4);   // weight buffer was cleared by reset

    for (int k = 0; k < DEPTH; k++) write_w(k, 64'h2 << (16*(3-k)));
    run_pass(4, 0, 1'b1, 1'b0, 1'b1, RES4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
